lc3b_mem_responder: RTL and testbench
=====================================

// Module: lc3b_mem_responder
// PURPOSE
//   Memory-side responder for the LC-3b mem_read/mem_write/mem_resp handshake.
//   Services word reads and byte-masked writes from the control/datapath
//   initiator against an internal word array, with a fixed, programmable latency.
//   Sits between the CPU top level and storage. It is the synthesizable stand-in
//   for the physical memory, used in simulation and in FPGA bring-up.
// PARAMETERS
//   ADDR_BITS  8  word-index width; array holds 2**ADDR_BITS 16-bit words
//   LATENCY    3  cycles from request accept to mem_resp; legal range 1..15
// PORTS
//   clk              in   1   clock; all state changes on posedge
//   rst              in   1   synchronous reset, active-high
//   mem_read         in   1   read request; held by initiator until mem_resp
//   mem_write        in   1   write request; held by initiator until mem_resp
//   mem_address      in   16  byte address; bit 0 ignored (word aligned)
//   mem_wdata        in   16  write data (lc3b_word)
//   mem_byte_enable  in   2   lc3b_mem_wmask; bit0 -> [7:0], bit1 -> [15:8]
//   mem_rdata        out  16  read data (lc3b_word); valid while mem_resp=1
//   mem_resp         out  1   one-cycle completion pulse
// BEHAVIOUR
//   Reset: state=IDLE, mem_resp=0, mem_rdata=16'h0000, counter=0.
//     Array contents are not reset.
//   FSM states:
//     IDLE: if (mem_read|mem_write), latch addr[ADDR_BITS:1], wdata, byte_enable
//       and op (write has priority if both are high; the op is then a write).
//       If LATENCY==1 go to RESP. Otherwise go to BUSY with cnt=LATENCY-2.
//     BUSY: if cnt==0 go to RESP, else cnt--. Inputs are ignored; latched values are used.
//     RESP: mem_resp=1 (a decode of the state). Next state is always IDLE.
//   Commit: on the edge entering RESP.
//     Write: bytes with be=1 update the array at the latched index.
//     Read: mem_rdata <= array[latched index].
//   Latency: request sampled at edge E0 -> mem_resp high in the cycle after edge
//     E0+LATENCY-1, i.e. exactly LATENCY cycles after the first request cycle.
//   mem_rdata holds its last read value until the next read commits.
//     Writes do not alter mem_rdata.
//   Back-to-back: after RESP, one IDLE cycle is mandatory.
//     A request held high then starts a new transaction, so minimum spacing is LATENCY+1 cycles.
//   Request dropped mid-BUSY: the transaction still completes, commits and pulses mem_resp.
//   be=2'b00 write: completes normally with mem_resp; array unchanged.
//   Address wrap: index = mem_address[ADDR_BITS:1]; upper bits are ignored.
//   rst in any state: return to IDLE next edge, mem_resp=0 and mem_rdata=0 that cycle;
//     any pending write is discarded (not committed).
//   mem_resp is never high for two consecutive cycles.
// STRUCTURE
//   lc3b_types package: reuse lc3b_word and lc3b_mem_wmask.
//     Add enum lc3b_memresp_state {mr_idle, mr_busy, mr_resp}.
//     Add constant LC3B_MEM_LATENCY_DEFAULT = 3.
//   Sub-module lc3b_mem_array: 2**ADDR_BITS x 16 storage.
//     One synchronous read port and one byte-masked synchronous write port.
//     No reset.
//   Top level: FSM, latency counter and request latches only.
// TESTING
//   1. rst high for 2 cycles -> mem_resp=0, mem_rdata=0000.
//      No mem_resp while idle with no request.
//   2. LATENCY=3: write 16'hBEEF @ x0010 be=11, then read x0010.
//      -> each mem_resp comes 3 cycles after the request rises; rdata=BEEF.
//   3. be=01 write 16'h1234 over BEEF @ x0010 -> read gives BE34.
//      be=10 write 16'h5600 -> read gives 5634. be=00 -> unchanged.
//   4. Read and write together, 16'hAAAA @ x0020 -> treated as a write.
//      mem_rdata keeps its prior value; a later read @ x0020 gives AAAA.
//   5. Assert rst during BUSY of a write 16'h7777 @ x0030 -> no mem_resp.
//      A later read of x0030 returns the old contents, not 7777.
//   6. LATENCY=1 with read held continuously -> mem_resp pulses every 2nd cycle.
//      Address x0202 aliases x0002 when ADDR_BITS=8.

Source files
------------

// File: rtl/lc3b_mem_responder_pkg.sv
// Shared LC-3b types for the memory responder: word and write-mask types,
// responder FSM encoding and the default response latency.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    mr_idle = 2'd0,
    mr_busy = 2'd1,
    mr_resp = 2'd2
  } lc3b_memresp_state;

  localparam int LC3B_MEM_LATENCY_DEFAULT = 3;

endpackage

// File: rtl/lc3b_mem_array.sv
// Word storage with one synchronous read port and one byte-masked synchronous
// write port. Contents are deliberately not reset.
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 re,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] index,
  input  lc3b_word             wdata,
  input  lc3b_mem_wmask        be,
  output lc3b_word             rdata
);

  lc3b_word mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) mem[index][7:0]  <= wdata[7:0];
      if (be[1]) mem[index][15:8] <= wdata[15:8];
    end
    if (re) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: accepts one read or byte-masked write, waits a fixed
// latency, commits against the word array and pulses mem_resp for one cycle.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = LC3B_MEM_LATENCY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       mem_address,
  input  lc3b_word          mem_wdata,
  input  lc3b_mem_wmask     mem_byte_enable,
  output lc3b_word          mem_rdata,
  output logic              mem_resp,
  output lc3b_memresp_state state
);

  // Handshake: the initiator raises mem_read or mem_write and holds the request
  // and its address/data until mem_resp; mem_resp is a single-cycle pulse with
  // mem_rdata valid in that cycle, and the responder is idle for one cycle after.

  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  lc3b_memresp_state next_state;
  logic [3:0]           cnt;
  logic [ADDR_BITS-1:0] lat_index;
  lc3b_word             lat_wdata;
  lc3b_mem_wmask        lat_be;
  logic                 lat_write;
  logic                 rdata_valid;

  logic                 req;
  logic                 from_idle;
  logic                 commit;
  logic [ADDR_BITS-1:0] arr_index;
  lc3b_word             arr_wdata;
  lc3b_mem_wmask        arr_be;
  logic                 arr_write;
  logic                 arr_re;
  logic                 arr_we;
  lc3b_word             arr_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, mem_address[0], mem_address[15:ADDR_BITS+1]};

  assign req = mem_read | mem_write;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= mr_idle;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      mr_idle: if (req) next_state = (LATENCY == 1) ? mr_resp : mr_busy;
      mr_busy: if (cnt == 4'd0) next_state = mr_resp;
      mr_resp: next_state = mr_idle;
      default: next_state = mr_idle;
    endcase
  end

  // Output logic
  always_comb begin
    mem_resp  = (state == mr_resp);
    mem_rdata = rdata_valid ? arr_rdata : 16'h0000;
  end

  // Latency counter and request latches
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      lat_index <= '0;
      lat_wdata <= 16'h0000;
      lat_be    <= 2'b00;
      lat_write <= 1'b0;
    end else begin
      case (state)
        mr_idle: begin
          if (req) begin
            cnt       <= CNT_LOAD;
            lat_index <= mem_address[ADDR_BITS:1];
            lat_wdata <= mem_wdata;
            lat_be    <= mem_byte_enable;
            lat_write <= mem_write;
          end
        end
        mr_busy: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // With LATENCY==1 the commit edge is also the accept edge, so the live
  // request feeds the array directly; otherwise the latched copy is used.
  assign from_idle = (state == mr_idle);
  assign arr_index = from_idle ? mem_address[ADDR_BITS:1] : lat_index;
  assign arr_wdata = from_idle ? mem_wdata : lat_wdata;
  assign arr_be    = from_idle ? mem_byte_enable : lat_be;
  assign arr_write = from_idle ? mem_write : lat_write;

  assign commit = !rst && (next_state == mr_resp) && (state != mr_resp);
  assign arr_we = commit && arr_write;
  assign arr_re = commit && !arr_write;

  // The array read register has no reset, so mem_rdata is masked to zero until
  // the first read after reset commits.
  always_ff @(posedge clk) begin
    if (rst)         rdata_valid <= 1'b0;
    else if (arr_re) rdata_valid <= 1'b1;
  end

  lc3b_mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (clk),
    .re    (arr_re),
    .we    (arr_we),
    .index (arr_index),
    .wdata (arr_wdata),
    .be    (arr_be),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder: LATENCY=3 and LATENCY=1 instances
// checked against a word-array model and an expected read-data queue.
module tb_lc3b_mem_responder;
  import lc3b_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        rd0, wr0, resp0;
  logic [15:0] addr0, wdata0, rdata0;
  logic [1:0]  be0;
  lc3b_memresp_state state0;

  logic        rd1, wr1, resp1;
  logic [15:0] addr1, wdata1, rdata1;
  logic [1:0]  be1;
  lc3b_memresp_state state1;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model0 [256];
  logic [15:0] model1 [256];

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(3)) dut0 (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .mem_address(addr0),
    .mem_wdata(wdata0), .mem_byte_enable(be0), .mem_rdata(rdata0),
    .mem_resp(resp0), .state(state0)
  );

  lc3b_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .mem_address(addr1),
    .mem_wdata(wdata1), .mem_byte_enable(be1), .mem_rdata(rdata1),
    .mem_resp(resp1), .state(state1)
  );

  function automatic logic get_resp(input int sel);
    return (sel != 0) ? resp1 : resp0;
  endfunction

  function automatic logic [15:0] get_rdata(input int sel);
    return (sel != 0) ? rdata1 : rdata0;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = d[7:0];
    if (be[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  task automatic drive_req(input int sel, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    if (sel != 0) begin
      rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d; be1 = be;
    end else begin
      rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d; be0 = be;
    end
  endtask

  task automatic clear_req(input int sel);
    drive_req(sel, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
  endtask

  // Push expectations when the request is driven; pop when mem_resp arrives.
  task automatic push_expect(input int sel, input logic rd, input logic wr,
                             input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [7:0] idx;
    idx = a[8:1];
    if (wr) begin
      if (sel != 0) model1[idx] = merge(model1[idx], d, be);
      else          model0[idx] = merge(model0[idx], d, be);
      exp_q.push_back(get_rdata(sel));
    end else if (rd) begin
      exp_q.push_back((sel != 0) ? model1[idx] : model0[idx]);
    end
  endtask

  task automatic txn(input int sel, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, input logic [1:0] be, input int lat,
                     input string name);
    int cycles;
    logic got;
    logic [15:0] exp;
    @(posedge clk); #1;
    drive_req(sel, rd, wr, a, d, be);
    push_expect(sel, rd, wr, a, d, be);
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (get_resp(sel)) got = 1'b1;
    end
    clear_req(sel);
    exp = exp_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no mem_resp within %0d cycles", name, cycles);
    end else begin
      if (cycles != lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cycles, lat);
      end
      checks++;
      if (get_rdata(sel) !== exp) begin
        errors++;
        $display("FAIL %s_rdata: got %h, expected %h", name, get_rdata(sel), exp);
      end
    end
  endtask

  task automatic test_reset();
    logic bad;
    rst = 1'b1;
    clear_req(0);
    clear_req(1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (resp0 !== 1'b0 || rdata0 !== 16'h0000 || state0 !== mr_idle) begin
      errors++;
      $display("FAIL reset_dut0: resp=%b rdata=%h state=%0d, expected 0 0000 0",
               resp0, rdata0, state0);
    end
    checks++;
    if (resp1 !== 1'b0 || rdata1 !== 16'h0000 || state1 !== mr_idle) begin
      errors++;
      $display("FAIL reset_dut1: resp=%b rdata=%h state=%0d, expected 0 0000 0",
               resp1, rdata1, state1);
    end
    rst = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp0 !== 1'b0 || resp1 !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL idle_no_resp: mem_resp seen while idle, expected none");
    end
  endtask

  task automatic test_basic();
    txn(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 3, "write_beef");
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 3, "read_beef");
  endtask

  task automatic test_byte_enable();
    txn(0, 1'b0, 1'b1, 16'h0010, 16'h1234, 2'b01, 3, "write_be01");
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 3, "read_be34");
    txn(0, 1'b0, 1'b1, 16'h0010, 16'h5600, 2'b10, 3, "write_be10");
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 3, "read_5634");
    txn(0, 1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, 3, "write_be00");
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 3, "read_unchanged");
  endtask

  task automatic test_write_priority();
    txn(0, 1'b1, 1'b1, 16'h0020, 16'hAAAA, 2'b11, 3, "rw_both");
    txn(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 3, "read_aaaa");
  endtask

  task automatic test_back_to_back();
    logic exp_resp;
    logic [15:0] exp;
    @(posedge clk); #1;
    drive_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
    push_expect(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
    push_expect(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      exp_resp = (c == 3 || c == 7);
      checks++;
      if (resp0 !== exp_resp) begin
        errors++;
        $display("FAIL b2b_resp_c%0d: got %b, expected %b", c, resp0, exp_resp);
      end
      if (exp_resp) begin
        exp = exp_q.pop_front();
        checks++;
        if (rdata0 !== exp) begin
          errors++;
          $display("FAIL b2b_rdata_c%0d: got %h, expected %h", c, rdata0, exp);
        end
      end
    end
    clear_req(0);
  endtask

  task automatic test_drop_mid_busy();
    int cycles;
    logic got;
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b1, 16'h0040, 16'h4321, 2'b11);
    model0[8'h20] = 16'h4321;
    @(posedge clk); #1;
    clear_req(0);
    cycles = 1;
    got = 1'b0;
    while (!got && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (resp0) got = 1'b1;
    end
    checks++;
    if (!got || cycles != 3) begin
      errors++;
      $display("FAIL drop_mid_busy: resp=%b after %0d cycles, expected 1 after 3", got, cycles);
    end
    txn(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 3, "read_dropped");
  endtask

  task automatic test_reset_busy();
    logic bad_resp, bad_rdata;
    txn(0, 1'b0, 1'b1, 16'h0030, 16'h1111, 2'b11, 3, "write_1111");
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b1, 16'h0030, 16'h7777, 2'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_req(0);
    bad_resp = 1'b0;
    bad_rdata = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (resp0 !== 1'b0) bad_resp = 1'b1;
      if (rdata0 !== 16'h0000) bad_rdata = 1'b1;
    end
    rst = 1'b0;
    checks++;
    if (bad_resp) begin
      errors++;
      $display("FAIL rst_busy_resp: mem_resp seen after reset, expected none");
    end
    checks++;
    if (bad_rdata) begin
      errors++;
      $display("FAIL rst_busy_rdata: rdata nonzero during reset, expected 0000");
    end
    checks++;
    if (state0 !== mr_idle) begin
      errors++;
      $display("FAIL rst_busy_state: got %0d, expected %0d", state0, mr_idle);
    end
    txn(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 3, "read_not_7777");
  endtask

  task automatic test_lat1_alias();
    logic exp_resp;
    txn(1, 1'b0, 1'b1, 16'h0202, 16'hC0DE, 2'b11, 1, "lat1_write_alias");
    txn(1, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 1, "lat1_read_alias");
    @(posedge clk); #1;
    drive_req(1, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      exp_resp = (i % 2 == 0);
      checks++;
      if (resp1 !== exp_resp) begin
        errors++;
        $display("FAIL lat1_pulse_%0d: got %b, expected %b", i, resp1, exp_resp);
      end
      if (exp_resp) begin
        checks++;
        if (rdata1 !== model1[8'h01]) begin
          errors++;
          $display("FAIL lat1_rdata_%0d: got %h, expected %h", i, rdata1, model1[8'h01]);
        end
      end
    end
    clear_req(1);
  endtask

  task automatic test_random();
    logic [15:0] a, d;
    logic [1:0] be;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom_range(0, 65535));
      d = 16'($urandom_range(0, 65535));
      be = 2'($urandom_range(0, 3));
      txn(0, 1'b0, 1'b1, a, d, be, 3, "rand_write");
      txn(0, 1'b0, 1'b1, a, 16'(~d), 2'b11, 3, "rand_write_full");
      txn(0, 1'b1, 1'b0, a ^ 16'hFE00, 16'h0000, 2'b00, 3, "rand_read_alias");
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_req(0);
    clear_req(1);
    test_reset();
    test_basic();
    test_byte_enable();
    test_write_priority();
    test_back_to_back();
    test_drop_mid_busy();
    test_reset_busy();
    test_lat1_alias();
    test_random();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
